// File: rtl/mult_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// mult_div_unit_pkg
// Shared definitions for the iterative multiply/divide unit: operation and
// FSM state encodings, iteration count, the divide-by-zero quotient value and
// small helpers that classify an operation code.
// -----------------------------------------------------------------------------
package mult_div_unit_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_ITER  = 32;
  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MADD  = 3'b100,
    OP_MADDU = 3'b101,
    OP_MSUB  = 3'b110,
    OP_MSUBU = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Even opcodes are the signed variants.
  function automatic logic op_is_signed(input op_e op);
    logic [2:0] v;
    v = op;
    return ~v[0];
  endfunction

  function automatic logic op_is_div(input op_e op);
    logic [2:0] v;
    v = op;
    return (v[2:1] == 2'b01);
  endfunction

  function automatic logic op_is_acc(input op_e op);
    logic [2:0] v;
    v = op;
    return v[2];
  endfunction

  function automatic logic op_is_sub(input op_e op);
    logic [2:0] v;
    v = op;
    return v[2] & v[1];
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// -----------------------------------------------------------------------------
// mdu_sign_fix
// Combinational sign handling around the unsigned iteration core.
//   Input side : i_a/i_b -> o_abs_a/o_abs_b (magnitudes when i_signed).
//   Output side: i_raw (unsigned product, or {remainder, quotient}) plus the
//                latched operand signs -> o_result, with negation, the
//                divide-by-zero quotient and MADD/MSUB accumulation applied
//                against i_hilo.
// -----------------------------------------------------------------------------
module mdu_sign_fix
  import mult_div_unit_pkg::*;
#(
  parameter int W = MDU_WIDTH
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  input  logic           i_signed,
  output logic [W-1:0]   o_abs_a,
  output logic [W-1:0]   o_abs_b,
  input  op_e            i_op,
  input  logic [2*W-1:0] i_raw,
  input  logic           i_neg_a,
  input  logic           i_neg_b,
  input  logic           i_div0,
  input  logic [2*W-1:0] i_hilo,
  output logic [2*W-1:0] o_result
);

  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;

  assign o_abs_a = (i_signed && i_a[W-1]) ? -i_a : i_a;
  assign o_abs_b = (i_signed && i_b[W-1]) ? -i_b : i_b;

  assign w_prod = (i_neg_a ^ i_neg_b) ? -i_raw : i_raw;

  // Remainder follows the dividend's sign (truncating division). With a zero
  // divisor the core leaves |A| in the remainder, so this restores A itself.
  assign w_rem = i_neg_a ? -i_raw[2*W-1:W] : i_raw[2*W-1:W];
  assign w_quo = i_div0 ? DIV0_LO[W-1:0]
               : ((i_neg_a ^ i_neg_b) ? -i_raw[W-1:0] : i_raw[W-1:0]);

  always_comb begin
    o_result = w_prod;
    if (op_is_div(i_op))      o_result = {w_rem, w_quo};
    else if (op_is_sub(i_op)) o_result = i_hilo - w_prod;
    else if (op_is_acc(i_op)) o_result = i_hilo + w_prod;
  end

endmodule

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative 32-bit multiply/divide unit feeding the Hi/Lo register.
// A Start accepted in IDLE runs ITER shift-add / restoring shift-subtract
// iterations, one FIX cycle for signs and accumulation, then one DONE cycle.
//   Clock, Reset (sync, active-low)
//   Start, Op[2:0], A, B     : request and operands (latched at Start)
//   HiLoIn[63:0]             : current {Hi,Lo}, read in FIX by MADD*/MSUB*
//   Busy                     : high whenever not IDLE
//   HiLoWriteData[63:0]      : result, held until the next FIX
//   HiLoWriteEnable          : one-cycle write pulse during DONE
// -----------------------------------------------------------------------------
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int ITER  = MDU_ITER
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [2:0]         Op,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2*WIDTH-1:0] HiLoIn,
  output logic               Busy,
  output logic [2*WIDTH-1:0] HiLoWriteData,
  output logic               HiLoWriteEnable
);

  localparam int CW = $clog2(ITER);

  state_e             r_state, w_state_nxt;
  logic [CW-1:0]      r_count;
  op_e                r_op;
  logic [WIDTH-1:0]   r_opnd;   // |A| for multiply, |B| for divide
  logic               r_neg_a, r_neg_b, r_div0;
  logic [2*WIDTH-1:0] r_p;      // product, or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] r_wdata;
  logic               r_we;

  op_e                w_op_in;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [2*WIDTH-1:0] w_result, w_p_nxt;
  logic [WIDTH:0]     w_sum, w_rem_sh, w_diff;
  logic               w_last;

  assign w_op_in = op_e'(Op);
  assign w_last  = (r_count == CW'(ITER - 1));

  mdu_sign_fix #(.W(WIDTH)) u_sign_fix (
    .i_a      (A),
    .i_b      (B),
    .i_signed (op_is_signed(w_op_in)),
    .o_abs_a  (w_abs_a),
    .o_abs_b  (w_abs_b),
    .i_op     (r_op),
    .i_raw    (r_p),
    .i_neg_a  (r_neg_a),
    .i_neg_b  (r_neg_b),
    .i_div0   (r_div0),
    .i_hilo   (HiLoIn),
    .o_result (w_result)
  );

  // Multiply step: add multiplicand into the upper half when the current
  // multiplier bit (LSB) is set, then shift the 65-bit result right.
  assign w_sum = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_opnd} : '0);

  // Divide step: shift the next dividend bit into the remainder and try a
  // subtract; the quotient bit fills the vacated LSB of the lower half.
  assign w_rem_sh = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_opnd};

  always_comb begin
    w_p_nxt = {w_sum, r_p[WIDTH-1:1]};
    if (op_is_div(r_op)) begin
      if (!w_diff[WIDTH]) w_p_nxt = {w_diff[WIDTH-1:0], r_p[WIDTH-2:0], 1'b1};
      else                w_p_nxt = {w_rem_sh[WIDTH-1:0], r_p[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_count <= '0;
      r_op    <= OP_MULT;
      r_opnd  <= '0;
      r_neg_a <= 1'b0;
      r_neg_b <= 1'b0;
      r_div0  <= 1'b0;
      r_p     <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: if (Start) begin
          r_op    <= w_op_in;
          r_count <= '0;
          r_neg_a <= op_is_signed(w_op_in) & A[WIDTH-1];
          r_neg_b <= op_is_signed(w_op_in) & B[WIDTH-1];
          r_div0  <= (B == '0);
          if (op_is_div(w_op_in)) begin
            r_opnd <= w_abs_b;
            r_p    <= {{WIDTH{1'b0}}, w_abs_a};
          end else begin
            r_opnd <= w_abs_a;
            r_p    <= {{WIDTH{1'b0}}, w_abs_b};
          end
        end
        S_RUN: begin
          r_p     <= w_p_nxt;
          r_count <= r_count + 1'b1;
        end
        S_FIX: begin
          r_wdata <= w_result;
          r_we    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Busy            = (r_state != S_IDLE);
  assign HiLoWriteData   = r_wdata;
  assign HiLoWriteEnable = r_we;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Scoreboard bench for mult_div_unit: the driver pushes the expected result
// and its write cycle when a request is accepted; a monitor pops and compares
// on every write pulse.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  Op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [63:0] HiLoIn = 64'd0;
  logic        Busy;
  logic [63:0] HiLoWriteData;
  logic        HiLoWriteEnable;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] data;
    int          wcyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] last_exp = 64'd0;

  mult_div_unit dut (
    .Clock           (Clock),
    .Reset           (Reset),
    .Start           (Start),
    .Op              (Op),
    .A               (A),
    .B               (B),
    .HiLoIn          (HiLoIn),
    .Busy            (Busy),
    .HiLoWriteData   (HiLoWriteData),
    .HiLoWriteEnable (HiLoWriteEnable)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on the architectural operation.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hilo);
    longint      sa, sb;
    logic [63:0] prod;
    logic [31:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 3'b010 || op == 3'b011) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (op == 3'b010) begin
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end else begin
        q = a / b;
        r = a % b;
      end
      return {r, q};
    end
    if (op[0]) prod = {32'd0, a} * {32'd0, b};
    else       prod = 64'(sa * sb);
    if (op[2:1] == 2'b10) return hilo + prod;
    if (op[2:1] == 2'b11) return hilo - prod;
    return prod;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, want);
    end
  endtask

  // Monitor: compare every write pulse against the scoreboard head.
  logic prev_we = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (HiLoWriteEnable === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("write_data", HiLoWriteData, e.data);
          check("write_cycle", 64'(cyc), 64'(e.wcyc));
        end
        check("single_pulse", 64'(prev_we), 64'd0);
      end
      prev_we = HiLoWriteEnable;
    end
  end

  // Called at a negedge with the unit idle; returns at the negedge where Busy has fallen.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] hilo, input bit noise);
    int k, n;
    Op = op; A = a; B = b; HiLoIn = hilo; Start = 1'b1;
    @(posedge Clock);
    #1;
    k = cyc;
    last_exp = model(op, a, b, hilo);
    exp_q.push_back('{data: last_exp, wcyc: k + 33});
    Start = 1'b0;
    Op = 3'($urandom); A = $urandom; B = $urandom;
    n = 0;
    @(negedge Clock);
    while (Busy === 1'b1 && n < 100) begin
      n++;
      if (noise) begin
        Start = 1'($urandom);
        Op = 3'($urandom); A = $urandom; B = $urandom;
      end
      @(negedge Clock);
    end
    Start = 1'b0;
    check("busy_cycles", 64'(n), 64'd34);
    check("data_hold", HiLoWriteData, last_exp);
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          sel;

    repeat (3) @(negedge Clock);
    check("reset_busy", 64'(Busy), 64'd0);
    check("reset_we", 64'(HiLoWriteEnable), 64'd0);
    check("reset_data", HiLoWriteData, 64'd0);
    Reset = 1'b1;
    @(negedge Clock);

    issue(3'b000, 32'hFFFF_FFFE, 32'd3, 64'd0, 1'b0);
    check("mult_neg", last_exp, 64'hFFFF_FFFF_FFFF_FFFA);
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0);
    issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 1'b0);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2, 64'd0, 1'b0);
    issue(3'b011, 32'd7, 32'd2, 64'd0, 1'b0);
    issue(3'b011, 32'd5, 32'd0, 64'd0, 1'b0);
    issue(3'b010, 32'hFFFF_FFF9, 32'd0, 64'd0, 1'b0);
    issue(3'b100, 32'd4, 32'd5, 64'h10, 1'b0);
    issue(3'b111, 32'd1, 32'd1, 64'd0, 1'b0);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 1'b0);
    issue(3'b110, 32'hFFFF_FFFD, 32'd7, 64'h1234_5678_9ABC_DEF0, 1'b0);

    // Abort a MULT ten cycles into RUN: outputs clear and no pulse follows.
    Op = 3'b000; A = 32'd9; B = 32'd9; Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    repeat (10) @(negedge Clock);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    check("abort_busy", 64'(Busy), 64'd0);
    check("abort_we", 64'(HiLoWriteEnable), 64'd0);
    check("abort_data", HiLoWriteData, 64'd0);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (40) @(negedge Clock);

    // Start strobes while busy must not disturb the result or its timing.
    issue(3'b000, 32'h1234_5678, 32'hFEDC_BA98, 64'd0, 1'b1);
    issue(3'b010, 32'h8765_4321, 32'h0000_1234, 64'd0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom);
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = 32'd0;
      else if (sel == 1) b = $urandom_range(1, 15);
      else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      issue(op, a, b, {$urandom, $urandom}, 1'($urandom));
    end

    repeat (3) @(negedge Clock);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit for the MIPS datapath, directly upstream of the 64-bit Hi/Lo register.
- Accepts an operation from the execute stage and iterates for 32 cycles.
- Produces the 64-bit {Hi,Lo} result with a one-cycle write-enable pulse that drives the Hi/Lo register's WriteData/WriteEnable.
- Also reads the current {Hi,Lo} value for the accumulate operations (MADD/MSUB).

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH.
- ITER, 32, iteration count; must equal WIDTH.

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-low; sampled on posedge Clock.
- Start  input  1  request strobe; sampled only in IDLE.
- Op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- A  input  32  rs operand (multiplicand / dividend).
- B  input  32  rt operand (multiplier / divisor).
- HiLoIn  input  64  current {Hi,Lo} register value; used by MADD*/MSUB*.
- Busy  output  1  high whenever state != IDLE.
- HiLoWriteData  output  64  result {Hi[63:32], Lo[31:0]}; feeds the Hi/Lo register WriteData.
- HiLoWriteEnable  output  1  one-cycle write pulse; feeds the Hi/Lo register WriteEnable.

Behaviour:
- Reset (Reset==0 at posedge):
  - state=IDLE; Busy=0, HiLoWriteEnable=0, HiLoWriteData=0; counter and internal registers cleared.
  - Reset in any state aborts the operation. No write pulse is ever issued for an aborted operation.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - If Start=1 at posedge k: latch Op, |A|, |B| (absolute values for signed ops), and the result-sign flags; count=0; go to RUN.
  - Start=0: remain in IDLE.
- RUN (posedges k+1..k+32), one iteration per cycle:
  - Multiply: shift-add, 64-bit unsigned product.
  - Divide: restoring shift-subtract, 32-bit quotient and remainder.
  - count increments; on count==ITER-1 go to FIX.
- FIX (posedge k+33):
  - Apply signs. Signed multiply negates the product if sign(A) != sign(B). Signed divide: quotient negated if signs differ; remainder takes the sign of A (truncation toward zero).
  - Accumulate ops: MADD* = HiLoIn + product; MSUB* = HiLoIn - product. HiLoIn is sampled at this edge; 64-bit wraparound, no overflow flag.
  - Register HiLoWriteData; set HiLoWriteEnable=1; go to DONE.
- DONE (posedge k+34): HiLoWriteEnable=0; go to IDLE.
- Timing:
  - Data and enable are stable for a full cycle, so they are captured by the Hi/Lo register's negedge write.
  - HiLoWriteData holds its value until the next FIX.
- Start handling:
  - Start is ignored while Busy=1, including during RUN, FIX and DONE.
  - Minimum issue interval is 35 cycles; the first accepted Start is at posedge k+35.
- Result layout:
  - Multiply: Hi = product[63:32], Lo = product[31:0].
  - Divide: Hi = remainder, Lo = quotient.
- Divide by zero (B==0): Hi=A (unmodified), Lo=32'hFFFFFFFF, for both DIV and DIVU. Latency is unchanged.
- Signed corner case: DIV 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0 (wraparound).
- Operands A/B/Op may change freely after the Start edge; only the latched copies are used.

Decomposition:
- Shared include mult_div_defs.vh holds:
  - Op encodings (OP_MULT..OP_MSUBU)
  - state encodings
  - ITER constant
  - DIV0_LO constant (32'hFFFFFFFF)
- One sub-module is natural: mdu_sign_fix, a combinational block computing absolute value on input and conditional negation / accumulate on output. The FSM and iteration datapath stay in mult_div_unit.

Test Plan:
- MULT A=0xFFFFFFFE, B=3 -> HiLoWriteEnable high exactly in cycle k+33 for one cycle; HiLoWriteData=0xFFFFFFFF_FFFFFFFA; Busy=1 from k+1 through k+34.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFE_00000001. MULT with the same operands -> 0x00000000_00000001.
- DIV A=0xFFFFFFF9 (-7), B=2 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFD. DIVU A=7, B=2 -> Hi=1, Lo=3.
- DIVU A=5, B=0 -> Hi=5, Lo=0xFFFFFFFF, same 33-cycle latency.
- MADD HiLoIn=0x00000000_00000010, A=4, B=5 -> 0x00000000_00000024. MSUBU HiLoIn=0, A=1, B=1 -> 0xFFFFFFFF_FFFFFFFF.
- Start MULT, drive Reset=0 at RUN cycle 10 -> all outputs 0 next cycle, no write pulse. Start pulses during RUN are ignored, with no change to the result or latency.
